// File: rtl/mem_arb_ctrl_pkg.sv
// Shared types for the multi-channel memory arbiter/controller.
// The state encodings match the single-port controller and the memory model.
package mem_arb_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // $clog2 that never returns 0, so a 1-entry range still gets a 1-bit field
  function automatic int clog2_min1(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/mem_arb_ctrl_if.sv
// Request/response and memory-port bundle for mem_arb_ctrl.
// slave = controller view, master = clients plus memory model.
interface mem_arb_ctrl_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int SIZE_W = 2
);
  logic [NUM_CH-1:0]        I_exec;
  logic [NUM_CH-1:0]        I_write;
  logic [NUM_CH*SIZE_W-1:0] I_size;
  logic [NUM_CH*ADDR_W-1:0] I_addr;
  logic [NUM_CH*DATA_W-1:0] I_data;
  logic [NUM_CH-1:0]        O_ack;
  logic [DATA_W-1:0]        O_data;
  logic [NUM_CH-1:0]        O_data_ready;
  logic [NUM_CH-1:0]        O_error;
  logic                     O_ready;
  logic                     MEM_ready;
  logic                     MEM_exec;
  logic                     MEM_write;
  logic [ADDR_W-1:0]        MEM_addr;
  logic [SIZE_W-1:0]        MEM_size;
  logic [DATA_W-1:0]        MEM_data_out;
  logic [DATA_W-1:0]        MEM_data_in;
  logic                     MEM_data_ready;

  modport slave (
    input  I_exec, I_write, I_size, I_addr, I_data,
    input  MEM_ready, MEM_data_in, MEM_data_ready,
    output O_ack, O_data, O_data_ready, O_error, O_ready,
    output MEM_exec, MEM_write, MEM_addr, MEM_size, MEM_data_out
  );

  modport master (
    output I_exec, I_write, I_size, I_addr, I_data,
    output MEM_ready, MEM_data_in, MEM_data_ready,
    input  O_ack, O_data, O_data_ready, O_error, O_ready,
    input  MEM_exec, MEM_write, MEM_addr, MEM_size, MEM_data_out
  );
endinterface

// File: rtl/mem_arb_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] gnt_idx_o,
  output logic          any_o
);
  int idx;

  // Walk the search order backwards so the last hit is the highest-priority one
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    idx       = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr_i) + i) % N;
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = PW'(idx);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/mem_arb_ctrl.sv
// NUM_CH clients share one memory port: round-robin grant, registered command
// drive, registered read data and a read timeout for a memory that never answers.
module mem_arb_ctrl
  import mem_arb_ctrl_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int SIZE_W  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic            I_clk,
  input  logic            I_reset,
  mem_arb_ctrl_if.slave   bus
);
  localparam int PW = clog2_min1(NUM_CH);
  localparam int CW = clog2_min1(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [PW-1:0]       rr_q, rr_d;
  logic [PW-1:0]       own_q, own_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_CH-1:0]   ack_q, ack_d;
  logic [NUM_CH-1:0]   drdy_q, drdy_d;
  logic [NUM_CH-1:0]   err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mexec_q, mexec_d;
  logic                mwrite_q, mwrite_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [SIZE_W-1:0]   msize_q, msize_d;
  logic [DATA_W-1:0]   mwdata_q, mwdata_d;

  logic [NUM_CH-1:0]   gnt;
  logic [PW-1:0]       gidx;
  logic                any;

  rr_arbiter #(.N(NUM_CH), .PW(PW)) u_arb (
    .req_i     (bus.I_exec),
    .ptr_i     (rr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gidx),
    .any_o     (any)
  );

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    own_d    = own_q;
    cnt_d    = cnt_q;
    ack_d    = '0;
    drdy_d   = '0;
    err_d    = '0;
    rdata_d  = rdata_q;
    mexec_d  = 1'b0;
    mwrite_d = mwrite_q;
    maddr_d  = maddr_q;
    msize_d  = msize_q;
    mwdata_d = mwdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.MEM_ready && any) begin
          state_d  = ST_ISSUE;
          mexec_d  = 1'b1;
          ack_d    = gnt;
          own_d    = gidx;
          rr_d     = (gidx == PW'(NUM_CH - 1)) ? '0 : gidx + 1'b1;
          mwrite_d = bus.I_write[gidx];
          maddr_d  = bus.I_addr[gidx*ADDR_W +: ADDR_W];
          msize_d  = bus.I_size[gidx*SIZE_W +: SIZE_W];
          mwdata_d = bus.I_data[gidx*DATA_W +: DATA_W];
        end
      end
      ST_ISSUE: begin
        state_d = mwrite_q ? ST_DONE : ST_RD_WAIT;
        cnt_d   = '0;
      end
      ST_RD_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // Data arriving on the timeout cycle still completes normally
        if (bus.MEM_data_ready) begin
          rdata_d        = bus.MEM_data_in;
          drdy_d[own_q]  = 1'b1;
          state_d        = ST_DONE;
        end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
          err_d[own_q]   = 1'b1;
          state_d        = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.MEM_ready) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q  <= ST_IDLE;
      rr_q     <= '0;
      own_q    <= '0;
      cnt_q    <= '0;
      ack_q    <= '0;
      drdy_q   <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
      mexec_q  <= 1'b0;
      mwrite_q <= 1'b0;
      maddr_q  <= '0;
      msize_q  <= '0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      own_q    <= own_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      drdy_q   <= drdy_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      mexec_q  <= mexec_d;
      mwrite_q <= mwrite_d;
      maddr_q  <= maddr_d;
      msize_q  <= msize_d;
      mwdata_q <= mwdata_d;
    end
  end

  assign bus.O_ack        = ack_q;
  assign bus.O_data       = rdata_q;
  assign bus.O_data_ready = drdy_q;
  assign bus.O_error      = err_q;
  assign bus.O_ready      = (state_q == ST_IDLE) && bus.MEM_ready;
  assign bus.MEM_exec     = mexec_q;
  assign bus.MEM_write    = mwrite_q;
  assign bus.MEM_addr     = maddr_q;
  assign bus.MEM_size     = msize_q;
  assign bus.MEM_data_out = mwdata_q;

endmodule
